// File: rtl/funnel_ctrl_pn_if.sv
// Handshake and status bundle for the lane funnel controller.
// slave is the controller view, master the driving environment view.
interface funnel_ctrl_pn_if #(
  parameter int LANES = 4,
  parameter int SW    = 3,
  parameter int CNTW  = 16
);
  logic             t_0_req;
  logic             t_0_ack;
  logic             t_cfg_req;
  logic             t_cfg_ack;
  logic [3:0]       cfg_mode;
  logic [LANES-1:0] i_req;
  logic [LANES-1:0] i_ack;
  logic [SW-1:0]    sel;
  logic [3:0]       mode_q;
  logic             busy;
  logic             cfg_err;
  logic [CNTW-1:0]  word_cnt;

  modport slave (
    input  t_0_req, t_cfg_req, cfg_mode, i_ack,
    output t_0_ack, t_cfg_ack, i_req, sel,
    output mode_q, busy, cfg_err, word_cnt
  );

  modport master (
    output t_0_req, t_cfg_req, cfg_mode, i_ack,
    input  t_0_ack, t_cfg_ack, i_req, sel,
    input  mode_q, busy, cfg_err, word_cnt
  );
endinterface

// File: rtl/funnel_ctrl_pn.sv
// Funnels 2^m active lanes per beat into one 2^SW-slice target word.
// Slice position advances by the lane count; sel is its bit-reversal.
module funnel_ctrl_pn #(
  parameter int LANES = 4,
  parameter int SW    = 3,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  funnel_ctrl_pn_if.slave bus
);
  localparam int LOG2L = $clog2(LANES);
  localparam logic [3:0] MODE_RST = 4'(LOG2L);

  logic [SW-1:0]    state_q, state_d;
  logic [3:0]       mode_q, mode_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [SW:0]      reduct;
  logic [SW:0]      sum;
  logic [LANES-1:0] active;
  logic [SW-1:0]    sel_w;
  logic             progress;
  logic             last;
  logic             idle;
  logic             cfg_acc;

  always_comb begin
    reduct = (SW+1)'(1) << mode_q;
    for (int k = 0; k < LANES; k++) begin
      active[k] = (k < int'(reduct));
    end
    for (int i = 0; i < SW; i++) begin
      sel_w[i] = state_q[SW-1-i];
    end
    // inactive lanes are forced high so their acks never gate progress
    progress = bus.t_0_req & (&(bus.i_ack | ~active));
    sum      = {1'b0, state_q} + reduct;
    last     = (sum[SW-1:0] == '0);
    idle     = (state_q == '0);
    cfg_acc  = bus.t_cfg_req & idle;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (progress) begin
      state_d = sum[SW-1:0];
    end
    if (progress && last) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cfg_acc) begin
      if (bus.cfg_mode > MODE_RST) begin
        err_d = 1'b1;
      end else begin
        mode_d = bus.cfg_mode;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      mode_q  <= MODE_RST;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.i_req     = {LANES{bus.t_0_req}} & active;
  assign bus.t_0_ack   = progress & last;
  assign bus.t_cfg_ack = cfg_acc;
  assign bus.sel       = sel_w;
  assign bus.mode_q    = mode_q;
  assign bus.busy      = ~idle;
  assign bus.cfg_err   = err_q;
  assign bus.word_cnt  = cnt_q;
endmodule

// File: tb/tb_funnel_ctrl_pn.sv
// Directed table bench for funnel_ctrl_pn (LANES=4, SW=3),
// plus a CNTW=2 instance for counter wrap.
module tb_funnel_ctrl_pn;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  funnel_ctrl_pn_if #(.LANES(4), .SW(3), .CNTW(16)) bus ();
  funnel_ctrl_pn_if #(.LANES(4), .SW(3), .CNTW(2))  bus2 ();

  funnel_ctrl_pn #(.LANES(4), .SW(3), .CNTW(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  funnel_ctrl_pn #(.LANES(4), .SW(3), .CNTW(2)) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2.slave)
  );

  typedef struct packed {
    logic        rst;
    logic        req;
    logic        creq;
    logic [3:0]  cm;
    logic [3:0]  ack;
    logic [3:0]  ireq;
    logic [2:0]  sel;
    logic        tack;
    logic        cack;
    logic        busy;
    logic [3:0]  mode;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic rq, input logic cr,
    input logic [3:0] cm, input logic [3:0] ak,
    input logic [3:0] ir, input logic [2:0] sl,
    input logic ta, input logic ca, input logic bz,
    input logic [3:0] md, input logic er,
    input logic [15:0] cn
  );
    vec_t v;
    v.rst = r; v.req = rq; v.creq = cr; v.cm = cm;
    v.ack = ak; v.ireq = ir; v.sel = sl; v.tack = ta;
    v.cack = ca; v.busy = bz; v.mode = md; v.err = er;
    v.cnt = cn;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h",
               nm, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    //            rst rq cr cm    ack      ireq     sel    ta ca bz mode  er cnt
    vecs.push_back(mk(1, 0, 0, 4'd0, 4'b0000, 4'b0000, 3'b000, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b1111, 4'b1111, 3'b000, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b1111, 4'b1111, 3'b001, 1, 0, 1, 4'd2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'd0, 4'b0000, 4'b0000, 3'b000, 0, 1, 0, 4'd2, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 3'b000, 0, 0, 0, 4'd0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 3'b100, 0, 0, 1, 4'd0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 3'b010, 0, 0, 1, 4'd0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 3'b110, 0, 0, 1, 4'd0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 3'b001, 0, 0, 1, 4'd0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 3'b101, 0, 0, 1, 4'd0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 3'b011, 0, 0, 1, 4'd0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 3'b111, 1, 0, 1, 4'd0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 4'd1, 4'b0000, 4'b0000, 3'b000, 0, 1, 0, 4'd0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0011, 4'b0011, 3'b000, 0, 0, 0, 4'd1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b1101, 4'b0011, 3'b010, 0, 0, 1, 4'd1, 0, 2));
    vecs.push_back(mk(0, 1, 1, 4'd0, 4'b1101, 4'b0011, 3'b010, 0, 0, 1, 4'd1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b1101, 4'b0011, 3'b010, 0, 0, 1, 4'd1, 0, 2));
    vecs.push_back(mk(0, 0, 1, 4'd0, 4'b0011, 4'b0000, 3'b010, 0, 0, 1, 4'd1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0011, 4'b0011, 3'b010, 0, 0, 1, 4'd1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0011, 4'b0011, 3'b001, 0, 0, 1, 4'd1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0011, 4'b0011, 3'b011, 1, 0, 1, 4'd1, 0, 2));
    vecs.push_back(mk(0, 0, 1, 4'd5, 4'b0000, 4'b0000, 3'b000, 0, 1, 0, 4'd1, 0, 3));
    vecs.push_back(mk(0, 0, 1, 4'd3, 4'b0000, 4'b0000, 3'b000, 0, 1, 0, 4'd1, 1, 3));
    vecs.push_back(mk(0, 0, 1, 4'd2, 4'b0000, 4'b0000, 3'b000, 0, 1, 0, 4'd1, 1, 3));
    vecs.push_back(mk(0, 1, 1, 4'd1, 4'b1111, 4'b1111, 3'b000, 0, 1, 0, 4'd2, 1, 3));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b0011, 4'b0011, 3'b001, 0, 0, 1, 4'd1, 1, 3));
    vecs.push_back(mk(1, 1, 0, 4'd0, 4'b0011, 4'b1111, 3'b000, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b1111, 4'b1111, 3'b000, 0, 0, 0, 4'd2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0, 4'b1111, 4'b1111, 3'b001, 1, 0, 1, 4'd2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0, 4'b0000, 4'b0000, 3'b000, 0, 0, 0, 4'd2, 0, 1));

    rst = 1'b1;
    rst2 = 1'b1;
    bus.t_0_req = 1'b0;
    bus.t_cfg_req = 1'b0;
    bus.cfg_mode = 4'd0;
    bus.i_ack = 4'b0000;
    bus2.t_0_req = 1'b0;
    bus2.t_cfg_req = 1'b0;
    bus2.cfg_mode = 4'd0;
    bus2.i_ack = 4'b0000;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.t_0_req = vecs[i].req;
      bus.t_cfg_req = vecs[i].creq;
      bus.cfg_mode = vecs[i].cm;
      bus.i_ack = vecs[i].ack;
      #1;
      chk("i_req", i, 16'(bus.i_req), 16'(vecs[i].ireq));
      chk("sel", i, 16'(bus.sel), 16'(vecs[i].sel));
      chk("t_0_ack", i, 16'(bus.t_0_ack), 16'(vecs[i].tack));
      chk("t_cfg_ack", i, 16'(bus.t_cfg_ack), 16'(vecs[i].cack));
      chk("busy", i, 16'(bus.busy), 16'(vecs[i].busy));
      chk("mode_q", i, 16'(bus.mode_q), 16'(vecs[i].mode));
      chk("cfg_err", i, 16'(bus.cfg_err), 16'(vecs[i].err));
      chk("word_cnt", i, bus.word_cnt, vecs[i].cnt);
    end

    // counter wrap: 5 words of 2 beats on a 2-bit counter
    @(negedge clk);
    #1;
    chk("wrap_rst_cnt", 0, 16'(bus2.word_cnt), 16'd0);
    @(negedge clk);
    rst2 = 1'b0;
    bus2.t_0_req = 1'b1;
    bus2.i_ack = 4'b1111;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus2.t_0_ack) begin
        acks++;
        if (acks == 5) break;
      end
      @(negedge clk);
    end
    chk("wrap_acks", 0, 16'(acks), 16'd5);
    chk("wrap_cnt4", 0, 16'(bus2.word_cnt), 16'd0);
    @(negedge clk);
    bus2.t_0_req = 1'b0;
    #1;
    chk("wrap_cnt5", 0, 16'(bus2.word_cnt), 16'd1);
    chk("wrap_busy", 0, 16'(bus2.busy), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/funnel_ctrl_pn.md
FUNNEL_CTRL_PN -- requirements
Module: funnel_ctrl_pn

Interface
REQ-001 Parameter: LANES, default 4, number of initiator lanes; power of 2, 1..16.
REQ-002 Parameter: SW, default 3, select width; one target word = 2^SW lane-slices, SW >= log2(LANES).
REQ-003 Parameter: CNTW, default 16, width of the completed-word counter.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 t_0_req  in  1  target word request.
REQ-008 t_0_ack  out  1  target word fully delivered; combinational.
REQ-009 t_cfg_req  in  1  configuration request.
REQ-010 t_cfg_ack  out  1  configuration accepted; combinational.
REQ-011 cfg_mode  in  4  requested mode m; reduct = 2^m lanes per beat.
REQ-012 i_req  out  LANES  per-lane request.
REQ-013 i_ack  in  LANES  per-lane acknowledge.
REQ-014 sel  out  SW  slice select driven to the datapath mux.
REQ-015 mode_q  out  4  active mode register.
REQ-016 busy  out  1  partial word in flight.
REQ-017 cfg_err  out  1  sticky illegal-mode flag.
REQ-018 word_cnt  out  CNTW  completed target words.

Function
REQ-019 reduct SHALL equal 1 << mode_q; lanes 0..reduct-1 are active and the remaining lanes are inactive.
REQ-020 i_req[k] SHALL equal t_0_req & (k < reduct); an inactive lane SHALL never be requested, including when t_0_req is low.
REQ-021 progress SHALL equal t_0_req AND the AND of i_ack over the active lanes; i_ack on inactive lanes SHALL be ignored.
REQ-022 SW-bit state register: on progress, state SHALL become (state + reduct) mod 2^SW; otherwise it SHALL hold.
REQ-023 last SHALL equal ((state + reduct) mod 2^SW == 0).
REQ-024 t_0_ack SHALL equal progress & last; t_0_req SHALL be acknowledged exactly once per 2^SW/reduct beats.
REQ-025 sel SHALL be the bit-reversal of state (sel[i] = state[SW-1-i]); sel SHALL be valid in the same cycle as i_req.
REQ-026 busy SHALL equal (state != 0).
REQ-027 word_cnt SHALL increment by 1 on every t_0_ack cycle and wrap modulo 2^CNTW.
REQ-028 t_cfg_ack SHALL equal t_cfg_req & ~busy; configuration SHALL never be accepted mid-word.
REQ-029 On an accepted cfg with cfg_mode <= log2(LANES): mode_q SHALL load cfg_mode on the next edge and cfg_err SHALL be unchanged.
REQ-030 On an accepted cfg with cfg_mode > log2(LANES): cfg_err SHALL set, mode_q SHALL hold, and t_cfg_ack SHALL still assert.
REQ-031 Simultaneous cfg accept and progress at state 0: the beat SHALL use the old mode_q; the new mode applies from the next cycle.
REQ-032 For mode_q = log2(LANES) = SW, every beat is last; t_0_ack SHALL equal progress and state SHALL remain 0.
REQ-033 Deassertion of t_0_req mid-word SHALL hold state and sel; the word resumes on reassertion.
REQ-034 cfg_err SHALL clear only on reset.

Reset
REQ-035 While reset is high: state = 0, sel = 0, busy = 0, word_cnt = 0, cfg_err = 0, mode_q = log2(LANES).
REQ-036 Reset asserted mid-word SHALL abandon the partial word; no t_0_ack SHALL be issued for it after reset release.
REQ-037 The first progress after reset release SHALL use sel = 0.

Verification (LANES=4, SW=3)
REQ-038 Reset, mode 2, t_0_req=1, i_ack=4'hF -> beats with sel 000 then 001; t_0_ack on the 2nd beat; word_cnt=1.
REQ-039 Cfg mode 0, t_0_req=1, i_ack=4'b0001 -> i_req=4'b0001; sel sequence 000,100,010,110,001,101,011,111; t_0_ack on the 8th beat only.
REQ-040 Mode 1, i_ack[1] low for 3 cycles at state 2 -> state and sel (010) hold, no t_0_ack; after i_ack[1] rises, t_0_ack on the 4th beat.
REQ-041 t_cfg_req while busy=1 -> t_cfg_ack=0 until the word completes; cfg_mode=5 at idle -> t_cfg_ack=1, cfg_err=1, mode_q unchanged.
REQ-042 Reset asserted at state 6 in mode 1 -> all registers reset immediately; after release, next sel = 000 and word_cnt = 0.
REQ-043 CNTW=2, run 5 words -> word_cnt reads 1 after the 5th word (wrap).
